out_array_ctrl: RTL and testbench
=================================

# out_array_ctrl

Sequencer for the output-stationary PE array. It clears the array, reads weight and input vectors from the operand buffers, and skews them onto the array edges for K accumulation steps. It then waits out the PE multiply/add pipeline and drains accumulated scratch values column by column onto a valid/ready result stream. It sits between the operand buffers and the ROWS×COLS array of output-stationary PEs.

## Interface
- OUT_ARRAY_ROWS, 4, PE rows; one input lane per row
- OUT_ARRAY_COLS, 4, PE columns; one weight lane per column
- OUT_PE_WEIGHT_WIDTH, `OUT_PE_WEIGHT_WIDTH, weight lane width
- OUT_PE_INPUT_WIDTH, `OUT_PE_INPUT_WIDTH, input lane width
- OUT_PE_SCRATCH_WIDTH, `OUT_PE_SCRATCH_WIDTH, accumulator width
- OUT_K_WIDTH, 8, width of K length and buffer address
- w_clock  in  1  sole clock, rising edge
- w_reset  in  1  synchronous, active-high reset
- w_start  in  1  start a tile; sampled only in IDLE
- w_k_len  in  OUT_K_WIDTH  number of K steps; latched on accepted start
- w_busy  out  1  high in every state except IDLE
- w_done  out  1  one-cycle pulse when the last column is accepted
- w_buf_rd  out  1  read strobe to the weight and input buffers; data returns next cycle
- w_buf_addr  out  OUT_K_WIDTH  K index being read
- w_wgt_data  in  COLS×WEIGHT_WIDTH  weight vector from the buffer
- w_inp_data  in  ROWS×INPUT_WIDTH  input vector from the buffer
- w_pe_weight  out  COLS×WEIGHT_WIDTH  skewed weights to the top array edge
- w_pe_input  out  ROWS×INPUT_WIDTH  skewed inputs to the left array edge
- w_pe_ready  out  COLS  per-column PE ready; low clears that column
- w_pe_rw  out  COLS  per-column PE rw; 1 = compute/high-Z output, 0 = scratch on output
- w_pe_stream  out  COLS  driven 0 in all states; the forward chain is unused
- w_col_data  in  ROWS×SCRATCH_WIDTH  shared tri-state column output bus
- w_res_data  out  ROWS×SCRATCH_WIDTH  drained column
- w_res_col  out  clog2(COLS)  index of the drained column
- w_res_valid  out  1  result valid
- w_res_ready  in  1  result accepted on valid&&ready

## Operation
- States:
  - IDLE: pe_ready=0, pe_rw=1.
  - On w_start → CLEAR: one cycle, pe_ready=0, then FEED.
  - FEED: pe_ready=all 1, pe_rw=all 1.
    - Issues w_buf_rd for addr 0..k_len-1, one per cycle.
    - Returned vectors pass through the skew: row lane r delayed r cycles, column lane c delayed c cycles.
    - Lanes with no valid data are driven 0. This keeps PE zero-gating active and prevents stray products.
    - FEED lasts k_len + ROWS + COLS − 1 cycles: 1 cycle read latency plus the skew tail.
  - FLUSH: 3 cycles, operands 0, lets the PE operand register, multiply, and add settle.
  - DRAIN: for column c = 0..COLS−1:
    - Drive pe_rw[c]=0; all other columns keep pe_rw=1.
    - Wait one settle cycle, then capture w_col_data into w_res_data and assert w_res_valid.
    - Hold until w_res_ready, then advance c.
    - Only one pe_rw bit is ever 0, so the bus never has multiple drivers.
  - After the last column is accepted: DONE (1 cycle, w_done=1) → IDLE.
- k_len = 0: FEED is skipped (CLEAR → FLUSH). All results drain as 0.
- w_start while busy is ignored. w_k_len changes after acceptance have no effect.
- Accumulation happens only in the PEs. The controller does no arithmetic beyond counters.

## Timing
- Reset values:
  - Idle at 0: w_busy, w_done, w_buf_rd, w_buf_addr, w_pe_weight, w_pe_input, w_pe_ready, w_pe_stream, w_res_valid, w_res_data, w_res_col.
  - w_pe_rw resets to all 1.
  - State resets to IDLE.
- Start accepted in cycle t: CLEAR in t+1, first w_buf_rd in t+2.
- Tile latency with no backpressure: 2 + (k_len+ROWS+COLS−1) + 3 + 2·COLS + 1 cycles.
- w_res_data and w_res_col are stable while w_res_valid is high and ready is low.
- w_reset mid-operation:
  - Returns to IDLE next cycle and drops all valids.
  - pe_ready=0, which clears the PE scratch.
  - A partial tile is discarded.

## Configuration
- OUT_ARRAY_CTRL_PERF_CNT_EN defined:
  - Adds output w_cycle_count (32 bits).
  - Cleared on accepted start; increments every cycle w_busy=1, including backpressure stalls.
  - Holds its value in IDLE; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package/header (parameters.vh):
  - Default ROWS/COLS/K width.
  - State encoding localparams (IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE).
  - FLUSH length constant 3.
- Sub-module out_skew_buffer:
  - Parameterized LANES and WIDTH; lane i delayed i cycles.
  - Synchronous clear on w_reset.
  - Instantiated twice: weights and inputs.

## Test plan
- 2×2 array, k_len=1, W=[[1,2]], I=[[3],[4]] → results col0={3,4}, col1={6,8}; w_done after exactly 2+4+3+4+1 cycles.
- 4×4, k_len=8, random operands → every drained column equals the reference dot products; w_buf_addr walks 0..7 exactly once.
- w_res_ready held low 5 cycles on column 1 → w_res_data/w_res_col stable, exactly one pe_rw bit is 0 throughout, no lost column.
- k_len=0 → four all-zero results, no w_buf_rd pulses.
- w_reset asserted during FEED → next cycle IDLE, pe_ready=0. A following tile gives results uncontaminated by the aborted one.
- With OUT_ARRAY_CTRL_PERF_CNT_EN: w_cycle_count equals the tile latency plus stall cycles; w_start pulsed while busy is ignored.

Source files
------------

// File: rtl/out_array_ctrl_pkg.sv
// Shared definitions for the output-stationary array sequencer.
// Holds default array geometry, operand widths, the FLUSH length and the
// sequencer state encoding. Operand widths come from the OUT_PE_* macros
// and fall back to the defaults below when the build does not set them.

`ifndef OUT_PE_WEIGHT_WIDTH
`define OUT_PE_WEIGHT_WIDTH 8
`endif
`ifndef OUT_PE_INPUT_WIDTH
`define OUT_PE_INPUT_WIDTH 8
`endif
`ifndef OUT_PE_SCRATCH_WIDTH
`define OUT_PE_SCRATCH_WIDTH 32
`endif

package out_array_ctrl_pkg;

   localparam int unsigned OUT_ARRAY_ROWS_DEF       = 4;
   localparam int unsigned OUT_ARRAY_COLS_DEF       = 4;
   localparam int unsigned OUT_K_WIDTH_DEF          = 8;
   localparam int unsigned OUT_PE_WEIGHT_WIDTH_DEF  = `OUT_PE_WEIGHT_WIDTH;
   localparam int unsigned OUT_PE_INPUT_WIDTH_DEF   = `OUT_PE_INPUT_WIDTH;
   localparam int unsigned OUT_PE_SCRATCH_WIDTH_DEF = `OUT_PE_SCRATCH_WIDTH;

   // Cycles for the PE operand register, multiply and add to settle.
   localparam int unsigned FLUSH_LEN = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Index width that stays at least one bit for single-entry ranges.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/out_skew_buffer.sv
// Per-lane delay line that staircases a vector onto an array edge.
// Lane i passes through i+1 registers: one output register plus i cycles of
// skew, so lane i lags lane 0 by exactly i cycles.
// Ports:
//   w_clock  rising-edge clock
//   w_reset  synchronous active-high clear of every stage
//   w_din    LANES x WIDTH input vector, lane i at [i*WIDTH +: WIDTH]
//   w_dout   LANES x WIDTH skewed output vector

module out_skew_buffer #(
   parameter int unsigned LANES = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   w_clock,
   input  logic                   w_reset,
   input  logic [LANES*WIDTH-1:0] w_din,
   output logic [LANES*WIDTH-1:0] w_dout
);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH-1:0] pipe [i+1];

      // Shift register of depth i+1 for this lane.
      always_ff @(posedge w_clock) begin
         if (w_reset) begin
            for (int s = 0; s <= i; s++) pipe[s] <= '0;
         end else begin
            pipe[0] <= w_din[i*WIDTH +: WIDTH];
            for (int s = 1; s <= i; s++) pipe[s] <= pipe[s-1];
         end
      end

      assign w_dout[i*WIDTH +: WIDTH] = pipe[i];
   end

endmodule

// File: rtl/out_array_ctrl.sv
// Sequencer for a ROWS x COLS output-stationary PE array.
// Clears the array, streams K weight/input vectors from the operand buffers
// through edge skew buffers, waits out the PE pipeline, then drains one
// column at a time onto a valid/ready result stream.
// Optional macro OUT_ARRAY_CTRL_PERF_CNT_EN adds w_cycle_count, a count of
// busy cycles of the most recent tile.
// Ports:
//   w_clock, w_reset           clock, synchronous active-high reset
//   w_start, w_k_len           tile start (IDLE only) and K length
//   w_busy, w_done             not-idle flag, one-cycle completion pulse
//   w_buf_rd, w_buf_addr       operand buffer read strobe / K index
//   w_wgt_data, w_inp_data     buffer read data, valid the cycle after read
//   w_pe_weight, w_pe_input    skewed operands to the top / left edges
//   w_pe_ready, w_pe_rw        per-column clear and compute/output select
//   w_pe_stream                unused forward chain, held 0
//   w_col_data                 shared column output bus from the array
//   w_res_data/col/valid/ready drained column result stream
//   w_cycle_count              (macro only) busy cycle counter

module out_array_ctrl
   import out_array_ctrl_pkg::*;
#(
   parameter int unsigned OUT_ARRAY_ROWS       = OUT_ARRAY_ROWS_DEF,
   parameter int unsigned OUT_ARRAY_COLS       = OUT_ARRAY_COLS_DEF,
   parameter int unsigned OUT_PE_WEIGHT_WIDTH  = OUT_PE_WEIGHT_WIDTH_DEF,
   parameter int unsigned OUT_PE_INPUT_WIDTH   = OUT_PE_INPUT_WIDTH_DEF,
   parameter int unsigned OUT_PE_SCRATCH_WIDTH = OUT_PE_SCRATCH_WIDTH_DEF,
   parameter int unsigned OUT_K_WIDTH          = OUT_K_WIDTH_DEF
) (
   input  logic                                        w_clock,
   input  logic                                        w_reset,
   input  logic                                        w_start,
   input  logic [OUT_K_WIDTH-1:0]                      w_k_len,
   output logic                                        w_busy,
   output logic                                        w_done,
   output logic                                        w_buf_rd,
   output logic [OUT_K_WIDTH-1:0]                      w_buf_addr,
   input  logic [OUT_ARRAY_COLS*OUT_PE_WEIGHT_WIDTH-1:0]  w_wgt_data,
   input  logic [OUT_ARRAY_ROWS*OUT_PE_INPUT_WIDTH-1:0]   w_inp_data,
   output logic [OUT_ARRAY_COLS*OUT_PE_WEIGHT_WIDTH-1:0]  w_pe_weight,
   output logic [OUT_ARRAY_ROWS*OUT_PE_INPUT_WIDTH-1:0]   w_pe_input,
   output logic [OUT_ARRAY_COLS-1:0]                   w_pe_ready,
   output logic [OUT_ARRAY_COLS-1:0]                   w_pe_rw,
   output logic [OUT_ARRAY_COLS-1:0]                   w_pe_stream,
   input  logic [OUT_ARRAY_ROWS*OUT_PE_SCRATCH_WIDTH-1:0] w_col_data,
   output logic [OUT_ARRAY_ROWS*OUT_PE_SCRATCH_WIDTH-1:0] w_res_data,
   output logic [idx_width(OUT_ARRAY_COLS)-1:0]        w_res_col,
   output logic                                        w_res_valid,
   input  logic                                        w_res_ready
`ifdef OUT_ARRAY_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]                                 w_cycle_count
`endif
);

   localparam int unsigned COL_W     = idx_width(OUT_ARRAY_COLS);
   localparam int unsigned SKEW_TAIL = OUT_ARRAY_ROWS + OUT_ARRAY_COLS - 2;
   localparam int unsigned CNT_W     = $clog2((2**OUT_K_WIDTH) + OUT_ARRAY_ROWS + OUT_ARRAY_COLS);
   localparam int unsigned WGT_BITS  = OUT_ARRAY_COLS * OUT_PE_WEIGHT_WIDTH;
   localparam int unsigned INP_BITS  = OUT_ARRAY_ROWS * OUT_PE_INPUT_WIDTH;

   state_t                 state;
   logic [OUT_K_WIDTH-1:0] k_len_q;
   logic [CNT_W-1:0]       feed_cnt;
   logic [1:0]             flush_cnt;
   logic [COL_W-1:0]       drain_col;
   logic                   drain_phase;   // 0 = bus settle cycle, 1 = result offered
   logic                   rd_q;          // buffer data valid this cycle
   logic [WGT_BITS-1:0]    wgt_gated;
   logic [INP_BITS-1:0]    inp_gated;

   assign w_pe_stream = '0;

   // Lanes carry zero whenever no buffer read returned this cycle.
   assign wgt_gated = rd_q ? w_wgt_data : '0;
   assign inp_gated = rd_q ? w_inp_data : '0;

   // Read-data valid tracks the one-cycle buffer latency.
   always_ff @(posedge w_clock) begin
      if (w_reset) rd_q <= 1'b0;
      else         rd_q <= w_buf_rd;
   end

   // Sequencer state and all registered control outputs.
   always_ff @(posedge w_clock) begin
      if (w_reset) begin
         state       <= ST_IDLE;
         k_len_q     <= '0;
         feed_cnt    <= '0;
         flush_cnt   <= '0;
         drain_col   <= '0;
         drain_phase <= 1'b0;
         w_busy      <= 1'b0;
         w_done      <= 1'b0;
         w_buf_rd    <= 1'b0;
         w_buf_addr  <= '0;
         w_pe_ready  <= '0;
         w_pe_rw     <= '1;
         w_res_valid <= 1'b0;
         w_res_data  <= '0;
         w_res_col   <= '0;
      end else begin
         w_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (w_start) begin
                  k_len_q    <= w_k_len;
                  w_busy     <= 1'b1;
                  w_pe_ready <= '0;
                  state      <= ST_CLEAR;
               end
            end

            ST_CLEAR: begin
               w_pe_ready <= '1;
               if (k_len_q == '0) begin
                  flush_cnt <= '0;
                  state     <= ST_FLUSH;
               end else begin
                  w_buf_rd   <= 1'b1;
                  w_buf_addr <= '0;
                  feed_cnt   <= '0;
                  state      <= ST_FEED;
               end
            end

            // Reads run for k_len cycles; the rest of FEED lets the skew tail drain.
            ST_FEED: begin
               feed_cnt <= feed_cnt + CNT_W'(1);
               if (w_buf_rd) begin
                  if (w_buf_addr == k_len_q - OUT_K_WIDTH'(1)) w_buf_rd <= 1'b0;
                  else w_buf_addr <= w_buf_addr + OUT_K_WIDTH'(1);
               end
               if (feed_cnt == CNT_W'(k_len_q) + CNT_W'(SKEW_TAIL)) begin
                  flush_cnt <= '0;
                  state     <= ST_FLUSH;
               end
            end

            ST_FLUSH: begin
               flush_cnt <= flush_cnt + 2'(1);
               if (flush_cnt == 2'(FLUSH_LEN - 1)) begin
                  drain_col   <= '0;
                  drain_phase <= 1'b0;
                  w_pe_rw     <= ~(OUT_ARRAY_COLS'(1));
                  state       <= ST_DRAIN;
               end
            end

            // Exactly one column drives the shared bus; it stays selected while stalled.
            ST_DRAIN: begin
               if (!drain_phase) begin
                  w_res_data  <= w_col_data;
                  w_res_col   <= drain_col;
                  w_res_valid <= 1'b1;
                  drain_phase <= 1'b1;
               end else if (w_res_ready) begin
                  w_res_valid <= 1'b0;
                  drain_phase <= 1'b0;
                  if (drain_col == COL_W'(OUT_ARRAY_COLS - 1)) begin
                     w_pe_rw <= '1;
                     w_done  <= 1'b1;
                     state   <= ST_DONE;
                  end else begin
                     drain_col <= drain_col + COL_W'(1);
                     w_pe_rw   <= ~(OUT_ARRAY_COLS'(1) << (drain_col + COL_W'(1)));
                  end
               end
            end

            ST_DONE: begin
               w_busy     <= 1'b0;
               w_pe_ready <= '0;
               state      <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   out_skew_buffer #(
      .LANES (OUT_ARRAY_COLS),
      .WIDTH (OUT_PE_WEIGHT_WIDTH)
   ) u_wgt_skew (
      .w_clock (w_clock),
      .w_reset (w_reset),
      .w_din   (wgt_gated),
      .w_dout  (w_pe_weight)
   );

   out_skew_buffer #(
      .LANES (OUT_ARRAY_ROWS),
      .WIDTH (OUT_PE_INPUT_WIDTH)
   ) u_inp_skew (
      .w_clock (w_clock),
      .w_reset (w_reset),
      .w_din   (inp_gated),
      .w_dout  (w_pe_input)
   );

`ifdef OUT_ARRAY_CTRL_PERF_CNT_EN
   // Busy-cycle counter, restarted by each accepted start.
   always_ff @(posedge w_clock) begin
      if (w_reset)                           w_cycle_count <= '0;
      else if (state == ST_IDLE && w_start)  w_cycle_count <= '0;
      else if (w_busy)                       w_cycle_count <= w_cycle_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_out_array_ctrl.sv
// Bench for out_array_ctrl: operand buffer model, behavioural
// output-stationary PE array, reference dot products and a result scoreboard.

module tb_out_array_ctrl;

   localparam int R  = 4;
   localparam int C  = 4;
   localparam int WW = 8;
   localparam int IW = 8;
   localparam int SW = 32;
   localparam int KW = 8;

   typedef struct {
      int k;
      int pattern;     // 0 = small fixed example, 1 = random, 2 = all-ones max
      int stall_col;   // column held off by ready low (0 = none)
      int stall_len;
      bit mid_start;   // pulse start while busy
      int exp_lat;     // cycles from accepting start through DONE, inclusive
      int exp_rd;
   } tile_vec_t;

   typedef struct {
      logic [1:0]      col;
      logic [R*SW-1:0] data;
   } exp_t;

   logic clk, reset, start, res_ready;
   logic [KW-1:0] k_len;
   logic busy, done, buf_rd, res_valid;
   logic [KW-1:0] buf_addr;
   logic [C*WW-1:0] wgt_data, pe_weight;
   logic [R*IW-1:0] inp_data, pe_input;
   logic [C-1:0] pe_ready, pe_rw, pe_stream;
   logic [R*SW-1:0] col_data, res_data;
   logic [1:0] res_col;
`ifdef OUT_ARRAY_CTRL_PERF_CNT_EN
   logic [31:0] cycle_count;
`endif

   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   tile_vec_t tiles[6];

   logic [C*WW-1:0] wmem [256];
   logic [R*IW-1:0] imem [256];

   out_array_ctrl dut (
      .w_clock(clk), .w_reset(reset), .w_start(start), .w_k_len(k_len),
      .w_busy(busy), .w_done(done), .w_buf_rd(buf_rd), .w_buf_addr(buf_addr),
      .w_wgt_data(wgt_data), .w_inp_data(inp_data),
      .w_pe_weight(pe_weight), .w_pe_input(pe_input),
      .w_pe_ready(pe_ready), .w_pe_rw(pe_rw), .w_pe_stream(pe_stream),
      .w_col_data(col_data), .w_res_data(res_data), .w_res_col(res_col),
      .w_res_valid(res_valid), .w_res_ready(res_ready)
`ifdef OUT_ARRAY_CTRL_PERF_CNT_EN
      , .w_cycle_count(cycle_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Operand buffers: one-cycle read latency.
   always @(posedge clk) begin
      if (buf_rd) begin
         wgt_data <= wmem[buf_addr];
         inp_data <= imem[buf_addr];
      end
   end

   // PE array: operand registers pass right/down, then multiply, then accumulate.
   logic [IW-1:0] a_reg [R][C];
   logic [WW-1:0] b_reg [R][C];
   logic [SW-1:0] prod  [R][C];
   logic [SW-1:0] acc   [R][C];

   always @(posedge clk) begin
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            int cl, ru;
            cl = (c == 0) ? 0 : c - 1;
            ru = (r == 0) ? 0 : r - 1;
            if (!pe_ready[c]) begin
               a_reg[r][c] <= '0;
               b_reg[r][c] <= '0;
               prod[r][c]  <= '0;
               acc[r][c]   <= '0;
            end else begin
               a_reg[r][c] <= (c == 0) ? pe_input[r*IW +: IW] : a_reg[r][cl];
               b_reg[r][c] <= (r == 0) ? pe_weight[c*WW +: WW] : b_reg[ru][c];
               prod[r][c]  <= SW'(a_reg[r][c]) * SW'(b_reg[r][c]);
               acc[r][c]   <= acc[r][c] + prod[r][c];
            end
         end
      end
   end

   // Shared column bus: columns with rw=0 drive their scratch.
   always_comb begin
      col_data = '0;
      for (int c = 0; c < C; c++)
         for (int r = 0; r < R; r++)
            if (!pe_rw[c]) col_data[r*SW +: SW] = col_data[r*SW +: SW] | acc[r][c];
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_mem(input int pattern, input int k);
      for (int i = 0; i < 256; i++) begin
         wmem[i] = '0;
         imem[i] = '0;
      end
      for (int i = 0; i < k; i++) begin
         for (int c = 0; c < C; c++)
            wmem[i][c*WW +: WW] = (pattern == 2) ? 8'hFF : WW'($urandom_range(255));
         for (int r = 0; r < R; r++)
            imem[i][r*IW +: IW] = (pattern == 2) ? 8'hFF : IW'($urandom_range(255));
      end
      if (pattern == 0) begin
         wmem[0] = {8'd0, 8'd0, 8'd2, 8'd1};
         imem[0] = {8'd0, 8'd0, 8'd4, 8'd3};
      end
   endtask

   // Reference column results: res[c][r] = sum_k W[k][c] * I[k][r].
   task automatic push_expected(input int k);
      for (int c = 0; c < C; c++) begin
         exp_t e;
         e.col  = 2'(c);
         e.data = '0;
         for (int r = 0; r < R; r++) begin
            logic [SW-1:0] s;
            s = '0;
            for (int i = 0; i < k; i++)
               s = s + SW'(wmem[i][c*WW +: WW]) * SW'(imem[i][r*IW +: IW]);
            e.data[r*SW +: SW] = s;
         end
         sb.push_back(e);
      end
   endtask

   task automatic run_tile(input tile_vec_t v);
      int lat, rd_n, stall_left, busy_n, rw_bad, addr_bad;
      bit seen_done, have_hold;
      logic [R*SW-1:0] hold_d;
      logic [1:0] hold_c;
      lat = 2; rd_n = 0; stall_left = 0; busy_n = 0; rw_bad = 0; addr_bad = 0;
      seen_done = 0; have_hold = 0; hold_d = '0; hold_c = '0;
      load_mem(v.pattern, v.k);
      push_expected(v.k);
      @(posedge clk); #2; start = 1'b1; k_len = KW'(v.k);
      @(posedge clk); #2; start = 1'b0; k_len = KW'(v.k + 5);
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if ($countones(~pe_rw) > 1) rw_bad++;
         if (buf_rd) begin
            if (buf_addr != KW'(rd_n)) addr_bad++;
            rd_n++;
         end
         if (res_valid && res_ready) begin
            if (sb.size() == 0) check("sb_empty", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               check("res_col", res_col, e.col);
               check("res_data", res_data, e.data);
            end
            if (v.stall_len > 0 && int'(res_col) == v.stall_col - 1) stall_left = v.stall_len;
         end else if (res_valid && !res_ready) begin
            if (have_hold) begin
               check("stall_data", res_data, hold_d);
               check("stall_col", res_col, hold_c);
            end else begin
               have_hold = 1;
               hold_d = res_data;
               hold_c = res_col;
            end
            if (stall_left > 0) stall_left--;
         end
         if (done) begin
            seen_done = 1;
            break;
         end
         @(posedge clk); #2;
         lat++;
         res_ready = (stall_left == 0);
         if (v.mid_start && cyc == 4) begin
            start = 1'b1; k_len = '0;
         end else start = 1'b0;
      end
      check("done_seen", seen_done, 1);
      check("latency", lat, v.exp_lat);
      check("rd_count", rd_n, v.exp_rd);
      check("addr_walk", addr_bad, 0);
      check("rw_onehot", rw_bad, 0);
      check("sb_drained", sb.size(), 0);
      if (v.stall_len > 0) check("stall_seen", have_hold, 1);
      @(posedge clk); #2;
      @(negedge clk);
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
`ifdef OUT_ARRAY_CTRL_PERF_CNT_EN
      check("cycle_count", cycle_count, busy_n);
`endif
      sb.delete();
   endtask

   initial begin
      tile_vec_t post_rst;
      // Latency = 2 + (k+R+C-1) + 3 + 2C + 1 (+ stall) = k + 21 for 4x4; k=0 skips FEED.
      tiles[0] = '{k: 1,   pattern: 0, stall_col: 0, stall_len: 0, mid_start: 0, exp_lat: 22,  exp_rd: 1};
      tiles[1] = '{k: 8,   pattern: 1, stall_col: 0, stall_len: 0, mid_start: 0, exp_lat: 29,  exp_rd: 8};
      tiles[2] = '{k: 8,   pattern: 1, stall_col: 1, stall_len: 5, mid_start: 1, exp_lat: 34,  exp_rd: 8};
      tiles[3] = '{k: 0,   pattern: 1, stall_col: 0, stall_len: 0, mid_start: 0, exp_lat: 14,  exp_rd: 0};
      tiles[4] = '{k: 3,   pattern: 2, stall_col: 0, stall_len: 0, mid_start: 0, exp_lat: 24,  exp_rd: 3};
      tiles[5] = '{k: 255, pattern: 1, stall_col: 0, stall_len: 0, mid_start: 0, exp_lat: 276, exp_rd: 255};

      reset = 1'b1; start = 1'b0; k_len = '0; res_ready = 1'b1;
      wgt_data = '0; inp_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_buf_rd", buf_rd, 0);
      check("rst_buf_addr", buf_addr, 0);
      check("rst_pe_weight", pe_weight, 0);
      check("rst_pe_input", pe_input, 0);
      check("rst_pe_ready", pe_ready, 0);
      check("rst_pe_rw", pe_rw, 4'hF);
      check("rst_pe_stream", pe_stream, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_col", res_col, 0);
      @(posedge clk); #2; reset = 1'b0;

      for (int i = 0; i < 6; i++) run_tile(tiles[i]);

      // Abort a tile of max operands in FEED, then check a clean tile afterwards.
      load_mem(2, 8);
      @(posedge clk); #2; start = 1'b1; k_len = 8'd8;
      @(posedge clk); #2; start = 1'b0;
      repeat (5) begin
         @(posedge clk); #2;
      end
      reset = 1'b1;
      @(negedge clk);
      check("pre_abort_busy", busy, 1);
      @(posedge clk); #2; reset = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_pe_ready", pe_ready, 0);
      check("abort_buf_rd", buf_rd, 0);
      check("abort_res_valid", res_valid, 0);
      check("abort_pe_stream", pe_stream, 0);
      repeat (2) @(posedge clk);
      #2;
      post_rst = '{k: 4, pattern: 1, stall_col: 0, stall_len: 0, mid_start: 0, exp_lat: 25, exp_rd: 4};
      run_tile(post_rst);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
